dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer placed in front of the single-port data memory bank in the MEM stage. It shares the bank between the pipeline load/store port (port 0) and an auxiliary port (port 1: debug/loader). Port 0 has priority, and a wait counter bounds port 1 starvation. Every memory strobe is driven from a register, so the combinational bank sees exactly one clean cycle per access.

## Interface
- DEPTH, 128: words in the bank; addresses at or above DEPTH are rejected with an error.
- MAX_WAIT, 4: consecutive denied port‑1 cycles after which port 1 takes priority (≥1).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- p0_req / p1_req  in  1  access request; held with we/addr/wdata stable until gnt
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  32  word address
- p0_wdata / p1_wdata  in  32  write data
- p0_gnt / p1_gnt  out  1  request accepted this cycle (combinational)
- p0_rvalid / p1_rvalid  out  1  one-cycle response pulse, two cycles after gnt
- p0_rdata / p1_rdata  out  32  read data, valid with rvalid; 0 for writes/errors
- p0_err / p1_err  out  1  with rvalid: address ≥ DEPTH, no access performed
- stall  out  1  p0_req & ~p0_gnt; freezes the pipeline
- mem_read  out  1  to bank memread
- mem_write  out  1  to bank memwrite
- mem_addr  out  32  to bank address
- mem_wdata  out  32  to bank writedata
- mem_rdata  in  32  from bank readdata

## Operation
- Arbitration, evaluated each cycle, at most one grant:
  - p1 wins if p1_req and wait_cnt == MAX_WAIT.
  - Otherwise p0 wins if p0_req.
  - Otherwise p1 wins if p1_req.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - Increments, saturating at MAX_WAIT, when p1_req & ~p1_gnt.
  - Clears on p1_gnt or when p1_req is low.
- Issue stage (registered), loaded on any grant:
  - owner, we, addr and wdata are captured.
  - oor = (addr ≥ DEPTH), compared on the full 32 bits.
  - mem_read = ~we & ~oor and mem_write = we & ~oor for exactly the next cycle.
  - With no grant, both strobes are 0 and mem_addr/mem_wdata hold their last values.
- Response stage (registered), loaded from the issue stage:
  - rdata = mem_rdata for reads that are not oor, else 0.
  - err = oor.
  - rvalid is pulsed on the owner port only.
- Throughput: one access per cycle, fully pipelined; back-to-back grants to either port are legal.
- Write followed by read to the same address on consecutive grants: the read returns the new data, because the write completes in its issue cycle.

## Timing
- Grant at cycle N → mem strobe high in N+1 → pN_rvalid/pN_rdata/pN_err in N+2.
- gnt and stall are combinational in the same cycle; all other outputs are registered.
- Reset values: mem_read = mem_write = 0; mem_addr = mem_wdata = 0; all rvalid/err = 0; all rdata = 0; wait_cnt = 0; issue/response valid = 0.
- Asserting reset mid-access immediately deasserts strobes. In-flight accesses are dropped with no rvalid, and a write already in its issue cycle may or may not have landed.
- gnt is 0 during reset; stall = p0_req during reset.
- Simultaneous p0_req and p1_req with wait_cnt < MAX_WAIT: p0 is granted, stall = 0, and wait_cnt increments.
- wait_cnt reaching MAX_WAIT while p1_req is held: p1 is granted on that cycle, stall = 1 if p0_req, and wait_cnt clears.
- A requester changing addr/we/wdata while its req is high and not granted violates the protocol; the arbiter samples only at gnt.

## Test plan
- After reset, p0 reads addr 5: p0_gnt at N, mem_read = 1 with mem_addr = 5 at N+1, p0_rvalid = 1 and p0_rdata = 500 at N+2. All other outputs stay 0.
- p0 writes 0xDEAD_BEEF to addr 11 at N, then reads addr 11 at N+1: mem_write is high for exactly one cycle (N+1), and p0_rdata = 0xDEADBEEF at N+3.
- p0_req and p1_req held continuously with MAX_WAIT = 4:
  - Grants follow the sequence p0, p0, p0, p0, p1, repeating.
  - stall = 1 exactly on the p1 cycles.
  - Each response arrives on the correct port two cycles after its grant.
- p1 reads addr 200 (DEPTH = 128): mem_read and mem_write stay 0, and at N+2 p1_rvalid = 1, p1_err = 1, p1_rdata = 0.
- Reset asserted asynchronously between clock edges while a write is at N+1: mem_write falls immediately, no rvalid follows, and after release the first access completes with 2-cycle latency.
- p1_req alone for 3 cycles, then dropped for 1 cycle, then p0 and p1 both requesting: wait_cnt has cleared, so p0 is granted first and p1 wins after 4 more denied cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data bank between the pipeline port (p0) and an aux port (p1).
// p0 has priority; a wait counter bounds p1 starvation. All bank strobes come from registers.
module dmem_arbiter #(
    parameter int DEPTH    = 128,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        p0_err,
    output logic        p1_err,
    output logic        stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt;
    logic          p1_due, grant, owner, sel_we, sel_oor;
    logic [31:0]   sel_addr, sel_wdata;
    logic          iss_valid, iss_owner, iss_oor;

    always_comb begin
        p1_due    = p1_req & (wait_cnt == WW'(MAX_WAIT));
        p0_gnt    = ~reset & p0_req & ~p1_due;
        p1_gnt    = ~reset & p1_req & ~p0_gnt;
        stall     = p0_req & ~p0_gnt;
        grant     = p0_gnt | p1_gnt;
        owner     = p1_gnt;
        sel_we    = owner ? p1_we : p0_we;
        sel_addr  = owner ? p1_addr : p0_addr;
        sel_wdata = owner ? p1_wdata : p0_wdata;
        sel_oor   = sel_addr >= 32'(DEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else
            wait_cnt <= (p1_req & ~p1_gnt) ? ((wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1) : '0;
    end

    // Issue stage: strobes are registered so the bank sees one clean cycle per access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid <= 1'b0;
            iss_owner <= 1'b0;
            iss_oor   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            iss_valid <= grant;
            iss_owner <= owner;
            iss_oor   <= sel_oor;
            mem_read  <= grant & ~sel_we & ~sel_oor;
            mem_write <= grant & sel_we & ~sel_oor;
            if (grant) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= iss_valid & ~iss_owner;
            p1_rvalid <= iss_valid & iss_owner;
            p0_err    <= iss_valid & ~iss_owner & iss_oor;
            p1_err    <= iss_valid & iss_owner & iss_oor;
            p0_rdata  <= (mem_read & ~iss_owner) ? mem_rdata : '0;
            p1_rdata  <= (mem_read & iss_owner) ? mem_rdata : '0;
        end
    end
endmodule
